fifo_burst_buffer: RTL and testbench

//  Single-clock synchronous FIFO that absorbs write bursts in front of (or behind) a
//  2-entry clock-domain-crossing data stage.

---
 rtl/fifo_burst_buffer_if.sv | 30 +++
 rtl/fifo_burst_buffer.sv | 115 +++++++++++
 tb/tb_fifo_burst_buffer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fifo_burst_buffer_if.sv
// rtl/fifo_burst_buffer_if.sv - write/read handshake bundle for fifo_burst_buffer
// Purpose: groups the producer-side and consumer-side valid/ready signals.
// Signals:
//   i_wdata  WIDTH  write data (producer -> FIFO)
//   i_wvalid 1      write request (producer -> FIFO)
//   o_wready 1      space available (FIFO -> producer)
//   o_rdata  WIDTH  head-of-queue data (FIFO -> consumer)
//   o_rvalid 1      queue non-empty (FIFO -> consumer)
//   i_rready 1      consumer accepts head (consumer -> FIFO)
// Modports: slave = FIFO side, master = producer/consumer side.
interface fifo_burst_buffer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] i_wdata;
  logic             i_wvalid;
  logic             o_wready;
  logic [WIDTH-1:0] o_rdata;
  logic             o_rvalid;
  logic             i_rready;

  modport slave (
    input  i_wdata, i_wvalid, i_rready,
    output o_wready, o_rdata, o_rvalid
  );

  modport master (
    output i_wdata, i_wvalid, i_rready,
    input  o_wready, o_rdata, o_rvalid
  );
endinterface

// File: rtl/fifo_burst_buffer.sv
// rtl/fifo_burst_buffer.sv - single-clock burst-absorbing FIFO with occupancy and high-water mark
// Purpose: first-word fall-through FIFO, one transfer per cycle on each side,
//   decoupling a bursty producer from a slower downstream drain.
// Ports:
//   i_clk          1      clock
//   i_rst          1      synchronous active-high reset, beats i_cg and all inputs
//   i_cg           1      clock gate; all state holds when 0
//   bus            slave  write/read handshake (see fifo_burst_buffer_if)
//   i_peakClear    1      clear high-water mark
//   o_nEntries     CW     occupancy 0..DEPTH
//   o_full         1      occupancy == DEPTH
//   o_empty        1      occupancy == 0
//   o_almostFull   1      occupancy >= ALMOST_FULL
//   o_peakEntries  CW     max occupancy since reset/last clear
module fifo_burst_buffer #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 4,
  parameter int ALMOST_FULL   = 3,
  parameter int FLOPS_NOT_MEM = 0,
  localparam int CW           = $clog2(DEPTH) + 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cg,
  fifo_burst_buffer_if.slave  bus,
  input  logic                i_peakClear,
  output logic [CW-1:0]       o_nEntries,
  output logic                o_full,
  output logic                o_empty,
  output logic                o_almostFull,
  output logic [CW-1:0]       o_peakEntries
);

  localparam int AW = CW - 1;

  logic [CW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] peak_q, peak_d;
  logic [CW-1:0] n_entries_d;
  logic          do_write, do_read;
  logic          wr_en;
  logic [AW-1:0] widx, ridx;

  assign widx = wptr_q[AW-1:0];
  assign ridx = rptr_q[AW-1:0];

  // Status comes from the registered pointers only, so no input reaches an
  // output combinationally.
  assign o_nEntries   = wptr_q - rptr_q;
  assign o_empty      = (wptr_q == rptr_q);
  assign o_full       = (widx == ridx) && (wptr_q[CW-1] != rptr_q[CW-1]);
  assign o_almostFull = (o_nEntries >= CW'(ALMOST_FULL));
  assign bus.o_wready = ~o_full;
  assign bus.o_rvalid = ~o_empty;
  assign o_peakEntries = peak_q;

  // o_full blocks writes even when a read happens in the same cycle.
  assign do_write = i_cg & bus.i_wvalid & ~o_full;
  assign do_read  = i_cg & ~o_empty & bus.i_rready;
  assign wr_en    = do_write & ~i_rst;

  always_comb begin
    wptr_d      = wptr_q + {{(CW-1){1'b0}}, do_write};
    rptr_d      = rptr_q + {{(CW-1){1'b0}}, do_read};
    n_entries_d = wptr_d - rptr_d;
    peak_d      = peak_q;
    if (i_cg) begin
      if (i_peakClear) begin
        peak_d = n_entries_d;
      end else if (n_entries_d > peak_q) begin
        peak_d = n_entries_d;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      peak_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      peak_q <= peak_d;
    end
  end

  // Storage is never reset; o_rdata is only meaningful while o_rvalid=1.
  generate
    if (FLOPS_NOT_MEM == 0) begin : g_mem
      logic [WIDTH-1:0] mem_q [DEPTH];

      always_ff @(posedge i_clk) begin
        if (wr_en) begin
          mem_q[widx] <= bus.i_wdata;
        end
      end

      assign bus.o_rdata = mem_q[ridx];
    end else begin : g_flops
      logic [WIDTH-1:0] ent_q [DEPTH];

      for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        always_ff @(posedge i_clk) begin
          if (wr_en && (widx == AW'(g))) begin
            ent_q[g] <= bus.i_wdata;
          end
        end
      end

      assign bus.o_rdata = ent_q[ridx];
    end
  endgenerate

endmodule

// File: tb/tb_fifo_burst_buffer.sv
// tb/tb_fifo_burst_buffer.sv - directed table-driven bench for fifo_burst_buffer
module tb_fifo_burst_buffer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cg;
  logic          peak_clear;
  logic [CW-1:0] n_entries;
  logic          full, empty, almost_full;
  logic [CW-1:0] peak_entries;

  int n_checks = 0;
  int n_fails  = 0;

  fifo_burst_buffer_if #(.WIDTH(WIDTH)) bus ();

  fifo_burst_buffer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ALMOST_FULL(AF), .FLOPS_NOT_MEM(0)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_cg(cg),
    .bus(bus),
    .i_peakClear(peak_clear),
    .o_nEntries(n_entries),
    .o_full(full),
    .o_empty(empty),
    .o_almostFull(almost_full),
    .o_peakEntries(peak_entries)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       rst;
    logic       cg;
    logic       wv;
    logic [7:0] wd;
    logic       rr;
    logic       pc;
    int         en;   // expected occupancy after the edge
    int         ep;   // expected peak after the edge
    logic [7:0] erd;  // expected head, checked when en != 0
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Full output check against an expected occupancy/peak/head; the flags are
  // derived here from the occupancy definitions.
  task automatic check_outputs(input string tag, input int en, input int ep, input logic [7:0] erd);
    chk({tag, " nEntries"}, int'(n_entries), en);
    chk({tag, " peak"}, int'(peak_entries), ep);
    chk({tag, " rvalid"}, int'(bus.o_rvalid), (en != 0) ? 1 : 0);
    chk({tag, " wready"}, int'(bus.o_wready), (en != DEPTH) ? 1 : 0);
    chk({tag, " full"}, int'(full), (en == DEPTH) ? 1 : 0);
    chk({tag, " empty"}, int'(empty), (en == 0) ? 1 : 0);
    chk({tag, " almostFull"}, int'(almost_full), (en >= AF) ? 1 : 0);
    if (en != 0) chk({tag, " rdata"}, int'(bus.o_rdata), int'(erd));
  endtask

  task automatic drive(input logic r, input logic c, input logic wv, input logic [7:0] wd,
                       input logic rr, input logic pc);
    rst          = r;
    cg           = c;
    bus.i_wvalid = wv;
    bus.i_wdata  = wd;
    bus.i_rready = rr;
    peak_clear   = pc;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(vecs[i].rst, vecs[i].cg, vecs[i].wv, vecs[i].wd, vecs[i].rr, vecs[i].pc);
      @(posedge clk);
      #1;
      check_outputs($sformatf("row%0d", i), vecs[i].en, vecs[i].ep, vecs[i].erd);
    end
  endtask

  initial begin
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    // rows 0-1: reset held with a write request pending
    vecs.push_back('{1'b1, 1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 0, 0, 8'h00});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 8'h98, 1'b0, 1'b0, 0, 0, 8'h00});
    // rows 2-6: fill to full, fifth write held off
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1, 1, 8'h11});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 2, 2, 8'h11});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 3, 3, 8'h11});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 4, 4, 8'h11});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 4, 4, 8'h11});
    // rows 7-8: full with both sides active -> read only, then both
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 3, 4, 8'h22});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 3, 4, 8'h33});
    // rows 9-12: drain, then read attempt on empty
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2, 4, 8'h44});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1, 4, 8'h55});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 4, 8'h00});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 4, 8'h00});
    // rows 13-16: fill to 3, clear peak while reading
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b0, 1, 4, 8'hA1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hA2, 1'b0, 1'b0, 2, 4, 8'hA1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 3, 4, 8'hA1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2, 2, 8'hA2});
    // rows 17-18: clock gate low with valid/ready/clear high -> nothing moves
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 2, 2, 8'hA2});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h78, 1'b1, 1'b1, 2, 2, 8'hA2});
    // rows 19-21: reset with 2 held (and cg low), write right after, read back
    vecs.push_back('{1'b1, 1'b0, 1'b1, 8'hEE, 1'b1, 1'b0, 0, 0, 8'h00});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1, 1, 8'hA5});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1, 8'h00});

    @(posedge clk);
    #1;
    run_rows(0, 1);

    // Streaming: 20 words with write and read held high. The first cycle
    // also clears the peak so it restarts at the post-edge occupancy of 1.
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b1, 1'b1, 8'(8'h60 + k), 1'b1, (k == 0) ? 1'b1 : 1'b0);
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d nEntries", k), int'(n_entries), 1);
      chk($sformatf("stream%0d rdata", k), int'(bus.o_rdata), 8'h60 + k);
      chk($sformatf("stream%0d rvalid", k), int'(bus.o_rvalid), 1);
    end
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("stream_end", 0, 1, 8'h00);

    run_rows(2, vecs.size() - 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
